// File: rtl/demux_14_tdm_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package demux_14_tdm_pkg;

    localparam int unsigned NUM_SLOTS = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/demux_14_tdm_slot_ctrl.sv
// Frame tracker for the TDM demux: follows slot position, decodes per-channel
// write enables and produces the registered valid / frame status pulses.
module demux_14_tdm_slot_ctrl
    import demux_14_tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic [NUM_SLOTS-1:0] wr_en,
    output logic [NUM_SLOTS-1:0] out_valid,
    output logic                 frame_valid,
    output logic                 frame_err,
    output slot_t                out_slot
);

    state_t state_q, state_d;
    slot_t  slot_q, slot_d;
    logic   fv_d, fe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            out_valid   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid   <= wr_en;
            frame_valid <= fv_d;
            frame_err   <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (in_valid) begin
            if (in_sof) begin
                // sof restarts the frame from either state
                state_d = RUN;
                slot_d  = slot_t'(1);
            end else if (state_q == RUN) begin
                if (slot_q == slot_t'(NUM_SLOTS - 1)) begin
                    state_d = IDLE;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + slot_t'(1);
                end
            end
        end
    end

    always_comb begin
        wr_en = '0;
        fv_d  = 1'b0;
        fe_d  = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                wr_en[0] = 1'b1;
                fe_d     = (state_q == RUN);
            end else if (state_q == IDLE) begin
                fe_d = 1'b1;
            end else begin
                wr_en[slot_q] = 1'b1;
                fv_d          = (slot_q == slot_t'(NUM_SLOTS - 1));
            end
        end
    end

    assign out_slot = (state_q == IDLE) ? '0 : slot_q;

endmodule

// File: rtl/demux_14_tdm.sv
// Time-division 1-to-4 demultiplexer: routes framed beats into four
// registered channel outputs and reports frame completion / framing errors.
module demux_14_tdm
    import demux_14_tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    output logic [1:0]       out_slot,
    output logic             frame_valid,
    output logic             frame_err
);

    logic [NUM_SLOTS-1:0] wr_en;
    logic [WIDTH-1:0]     data_q [NUM_SLOTS];

    demux_14_tdm_slot_ctrl u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .wr_en       (wr_en),
        .out_valid   (out_valid),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .out_slot    (out_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

endmodule
